// File: rtl/huffman_sequencer.sv
// Avalon-MM sequencer for the Huffman codeword LUT: it arbitrates LUT writes
// against symbol lookups and hands each codeword to the coder over valid/ready.
module huffman_sequencer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        mem_mode,
    output logic [5:0]  mem_addr,
    output logic [11:0] mem_data,
    input  logic [11:0] mem_q,
    output logic [7:0]  code,
    output logic [3:0]  length,
    output logic        code_valid,
    input  logic        coder_ready,
    output logic        busy
);

    localparam int unsigned CW = FIFO_AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LUTW, S_FETCH, S_WAIT, S_ISSUE} state_e;

    state_e state_q, state_d;

    logic [31:0]         readdata_q, readdata_d;
    logic                mem_mode_q, mem_mode_d;
    logic [5:0]          mem_addr_q, mem_addr_d;
    logic [11:0]         mem_data_q, mem_data_d;
    logic [7:0]          code_q, code_d;
    logic [3:0]          length_q, length_d;
    logic                code_valid_q, code_valid_d;
    logic                busy_q, busy_d;
    logic [15:0]         issued_q, issued_d;
    logic                pend_q, pend_d;
    logic [5:0]          lat_addr_q, lat_addr_d;
    logic [11:0]         lat_data_q, lat_data_d;
    logic                enable_q, enable_d;
    logic                overflow_q, overflow_d;
    logic                zero_len_q, zero_len_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [5:0]          fifo_mem_q [FIFO_DEPTH];

    logic ctrl_wr, lut_wr, sym_wr, rd_en, flush, clr_flags;
    logic fifo_empty, fifo_full, push_ok, push_drop;
    logic start_lutw, start_fetch, issue_done, zero_hit;
    logic [5:0]  fifo_head;
    logic [31:0] status_c;
    logic        unused_wdata;

    assign ctrl_wr      = chipselect & write & (address == 2'd0);
    assign lut_wr       = chipselect & write & (address == 2'd1);
    assign sym_wr       = chipselect & write & (address == 2'd2);
    assign rd_en        = chipselect & read;
    assign flush        = ctrl_wr & writedata[1];
    assign clr_flags    = ctrl_wr & writedata[2];
    assign unused_wdata = ^writedata[31:18];

    // A second LUT write stalls until the pending one has been taken into LUTW.
    assign waitrequest  = lut_wr & pend_q;

    assign fifo_empty = (count_q == CW'(0));
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    assign push_ok    = sym_wr & ~fifo_full & ~flush;
    assign push_drop  = sym_wr & fifo_full;

    assign start_lutw  = (state_q == S_IDLE) & pend_q;
    assign start_fetch = (state_q == S_IDLE) & ~pend_q & enable_q & ~fifo_empty;
    assign issue_done  = (state_q == S_ISSUE) & coder_ready;
    assign zero_hit    = (state_q == S_WAIT) & (mem_q[11:8] == 4'd0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_lutw)       state_d = S_LUTW;
                else if (start_fetch) state_d = S_FETCH;
            end
            S_LUTW:  state_d = S_IDLE;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = zero_hit ? S_IDLE : S_ISSUE;
            S_ISSUE: if (coder_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-driven outputs: LUT port and coder handshake
    always_comb begin
        mem_mode_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        code_d       = code_q;
        length_d     = length_q;
        code_valid_d = code_valid_q;
        issued_d     = issued_q;
        if (start_lutw) begin
            mem_mode_d = 1'b1;
            mem_addr_d = lat_addr_q;
            mem_data_d = lat_data_q;
        end else if (start_fetch) begin
            mem_addr_d = fifo_head;
        end
        if ((state_q == S_WAIT) && !zero_hit) begin
            code_d       = mem_q[7:0];
            length_d     = mem_q[11:8];
            code_valid_d = 1'b1;
        end
        if (issue_done) begin
            code_valid_d = 1'b0;
            issued_d     = issued_q + 16'd1;
        end
    end

    always_comb begin
        status_c             = 32'd0;
        status_c[FIFO_AW:0]  = count_q;
        status_c[8]          = fifo_empty;
        status_c[9]          = fifo_full;
        status_c[10]         = (state_q != S_IDLE) | ~fifo_empty;
        status_c[11]         = overflow_q;
        status_c[12]         = zero_len_q;
        status_c[31:16]      = issued_q;
    end

    // Register file, LUT write latch, flags and FIFO pointers
    always_comb begin
        pend_d     = pend_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        enable_d   = enable_q;
        overflow_d = overflow_q;
        zero_len_d = zero_len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        readdata_d = 32'd0;

        if (start_lutw) pend_d = 1'b0;
        if (lut_wr && !pend_q) begin
            pend_d     = 1'b1;
            lat_addr_d = writedata[5:0];
            lat_data_d = writedata[17:6];
        end

        if (ctrl_wr) enable_d = writedata[0];
        // Set beats clear when both land on the same edge.
        if (clr_flags) begin
            overflow_d = 1'b0;
            zero_len_d = 1'b0;
        end
        if (push_drop && !flush) overflow_d = 1'b1;
        if (zero_hit)            zero_len_d = 1'b1;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok)     wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            if (start_fetch) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            if (push_ok && !start_fetch)      count_d = count_q + CW'(1);
            else if (!push_ok && start_fetch) count_d = count_q - CW'(1);
        end

        if (rd_en) begin
            case (address)
                2'd0:    readdata_d = {31'd0, enable_q};
                2'd3:    readdata_d = status_c;
                default: readdata_d = 32'd0;
            endcase
        end

        busy_d = (state_d != S_IDLE) | (count_d != CW'(0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q   <= 32'd0;
            mem_mode_q   <= 1'b0;
            mem_addr_q   <= 6'd0;
            mem_data_q   <= 12'd0;
            code_q       <= 8'd0;
            length_q     <= 4'd0;
            code_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            issued_q     <= 16'd0;
            pend_q       <= 1'b0;
            lat_addr_q   <= 6'd0;
            lat_data_q   <= 12'd0;
            enable_q     <= 1'b0;
            overflow_q   <= 1'b0;
            zero_len_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            readdata_q   <= readdata_d;
            mem_mode_q   <= mem_mode_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            code_q       <= code_d;
            length_q     <= length_d;
            code_valid_q <= code_valid_d;
            busy_q       <= busy_d;
            issued_q     <= issued_d;
            pend_q       <= pend_d;
            lat_addr_q   <= lat_addr_d;
            lat_data_q   <= lat_data_d;
            enable_q     <= enable_d;
            overflow_q   <= overflow_d;
            zero_len_q   <= zero_len_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Symbol storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem_q[wr_ptr_q] <= writedata[5:0];
    end

    assign readdata   = readdata_q;
    assign mem_mode   = mem_mode_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign code       = code_q;
    assign length     = length_q;
    assign code_valid = code_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_huffman_sequencer.sv
// Directed bench for huffman_sequencer with a behavioural 64x12 synchronous LUT.
module tb_huffman_sequencer;

    logic        clock;
    logic        reset;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        mem_mode;
    logic [5:0]  mem_addr;
    logic [11:0] mem_data;
    logic [11:0] mem_q;
    logic [7:0]  code;
    logic [3:0]  length;
    logic        code_valid;
    logic        coder_ready;
    logic        busy;

    logic [11:0] lut [64];

    int n_assert = 0;
    int n_fail   = 0;

    huffman_sequencer #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .mem_mode    (mem_mode),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_q       (mem_q),
        .code        (code),
        .length      (length),
        .code_valid  (code_valid),
        .coder_ready (coder_ready),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_mode) lut[mem_addr] <= mem_data;
        mem_q <= lut[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int waits);
        waits      = 0;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clock);
        while (waitrequest && waits < 20) begin
            waits++;
            @(negedge clock);
        end
        if (waits >= 20) begin
            n_assert++;
            n_fail++;
            $error("FAIL write_timeout: observed waitrequest stuck expected release");
        end
        @(posedge clock);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(posedge clock);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    initial begin
        int          w0, w1;
        logic [31:0] rd;

        reset       = 1'b1;
        chipselect  = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        address     = 2'd0;
        writedata   = 32'd0;
        coder_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_readdata", readdata, 32'd0);
        check("rst_outputs", {31'd0, waitrequest | mem_mode | code_valid | busy}, 32'd0);
        check("rst_mem_bus", {14'd0, mem_addr, mem_data}, 32'd0);
        check("rst_coder_bus", {20'd0, length, code}, 32'd0);
        bus_read(2'd3, rd);
        check("rst_status", rd, 32'h0000_0100);

        // Single LUT write: addr 7, length 3, code 0x05
        bus_write(2'd1, 32'h0000_C147, w0);
        check("lutw_not_yet", {31'd0, mem_mode}, 32'd0);
        tick();
        check("lutw_mode", {31'd0, mem_mode}, 32'd1);
        check("lutw_addr", {26'd0, mem_addr}, 32'd7);
        check("lutw_data", {20'd0, mem_data}, 32'h305);
        tick();
        check("lutw_done", {31'd0, mem_mode}, 32'd0);

        // Back-to-back LUT writes: addr 3 (length 0), then addr 9 (length 8, code 0xFF)
        bus_write(2'd1, 32'h0000_2AC3, w0);
        bus_write(2'd1, 32'h0002_3FC9, w1);
        check("b2b_wait_first", w0, 32'd0);
        check("b2b_wait_second", w1, 32'd1);
        tick();
        check("b2b_mode", {31'd0, mem_mode}, 32'd1);
        check("b2b_addr_data", {14'd0, mem_addr, mem_data}, {14'd0, 6'd9, 12'h8FF});
        tick();
        check("b2b_done", {31'd0, mem_mode}, 32'd0);

        // Lookup of symbol 7 with coder ready
        bus_write(2'd0, 32'd1, w0);
        bus_write(2'd2, 32'd7, w0);
        check("lk_e0_valid", {31'd0, code_valid}, 32'd0);
        tick();
        check("lk_e1_fetch", {24'd0, code_valid, busy, mem_addr}, {24'd0, 1'b0, 1'b1, 6'd7});
        tick();
        check("lk_e2_valid", {31'd0, code_valid}, 32'd0);
        tick();
        check("lk_e3_issue", {19'd0, code_valid, length, code}, {19'd0, 1'b1, 4'd3, 8'h05});
        tick();
        check("lk_e4_accepted", {31'd0, code_valid}, 32'd0);
        bus_read(2'd3, rd);
        check("lk_status", rd, 32'h0001_0100);

        // Backpressure: symbol 9 held for five cycles
        coder_ready = 1'b0;
        bus_write(2'd2, 32'd9, w0);
        tick();
        tick();
        tick();
        check("bp_issue", {19'd0, code_valid, length, code}, {19'd0, 1'b1, 4'd8, 8'hFF});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {19'd0, code_valid, length, code}, {19'd0, 1'b1, 4'd8, 8'hFF});
        end
        coder_ready = 1'b1;
        tick();
        check("bp_release", {31'd0, code_valid}, 32'd0);
        bus_read(2'd3, rd);
        check("bp_status", rd, 32'h0002_0100);

        // Overflow with enable off, then clear flags, then flush
        bus_write(2'd0, 32'd0, w0);
        for (int i = 0; i < 17; i++) bus_write(2'd2, 32'(i), w0);
        bus_read(2'd3, rd);
        check("ovf_status", rd, 32'h0002_0E10);
        check("ovf_busy", {31'd0, busy}, 32'd1);
        bus_write(2'd0, 32'd4, w0);
        bus_read(2'd3, rd);
        check("clr_status", rd, 32'h0002_0610);
        bus_write(2'd0, 32'd2, w0);
        bus_read(2'd3, rd);
        check("flush_status", rd, 32'h0002_0100);

        // Zero-length entry for symbol 3
        bus_write(2'd0, 32'd1, w0);
        bus_write(2'd2, 32'd3, w0);
        tick();
        check("zl_fetch", {26'd0, mem_addr}, 32'd3);
        tick();
        check("zl_wait_valid", {31'd0, code_valid}, 32'd0);
        tick();
        check("zl_idle", {30'd0, code_valid, busy}, 32'd0);
        bus_read(2'd3, rd);
        check("zl_status", rd, 32'h0002_1100);
        bus_read(2'd0, rd);
        check("ctrl_read", rd, 32'd1);

        // Reset in the middle of an issue
        coder_ready = 1'b0;
        bus_write(2'd2, 32'd7, w0);
        tick();
        tick();
        tick();
        check("mid_issue", {31'd0, code_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_outputs", {24'd0, code_valid, busy, mem_addr}, 32'd0);
        bus_read(2'd3, rd);
        check("mid_rst_status", rd, 32'h0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_sequencer.md
Name: huffman_sequencer

Overview:
- Avalon-MM slave controller that sequences the Huffman codeword LUT (64 x 12-bit, synchronous RAM) and the coder.
- Software programs LUT entries and pushes 6-bit symbols into an internal FIFO.
- The block arbitrates LUT port use between programming and lookup, fetches each symbol's codeword, and hands code/length to the coder with a valid/ready handshake.

Parameters:
FIFO_DEPTH, 16, symbol FIFO entries (power of 2, >=2)
FIFO_AW, 4, log2(FIFO_DEPTH)

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high; all state cleared on the edge where it is high
chipselect  input  1  Avalon select
read  input  1  Avalon read strobe
write  input  1  Avalon write strobe
address  input  2  register index
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, registered, read latency 1
waitrequest  output  1  stall for LUT_WR access
mem_mode  output  1  LUT write enable (1=write, 0=read)
mem_addr  output  6  LUT address
mem_data  output  12  LUT write data {length[3:0],code[7:0]}
mem_q  input  12  LUT read data, valid one cycle after mem_addr sampled
code  output  8  codeword bits to coder
length  output  4  codeword length to coder
code_valid  output  1  code/length valid
coder_ready  input  1  coder accepts on edge when code_valid&coder_ready
busy  output  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Register map (access = chipselect&write, or chipselect&read):
  - 0 CTRL (W): bit0 enable (level, stored); bit1 flush (self-clearing); bit2 clear sticky flags.
  - 1 LUT_WR (W): [5:0] addr, [17:6] codeword.
  - 2 SYMBOL (W): [5:0] symbol pushed to FIFO.
  - 3 STATUS (R): [FIFO_AW:0] count, [8] empty, [9] full, [10] busy, [11] overflow sticky, [12] zero_len sticky, [31:16] issued-codeword counter (wraps at 65535->0).
  - Reads of 0-2 return {31'b0, enable} for 0; 0 otherwise.
- Reset values:
  - readdata=0, waitrequest=0, mem_mode=0, mem_addr=0, mem_data=0, code=0, length=0, code_valid=0.
  - FIFO empty, flags 0, counter 0, enable 0, FSM IDLE.
- FSM states: IDLE, LUTW, FETCH, WAIT, ISSUE.
  - IDLE: pending LUT write has priority over symbols → LUTW. Else if enable and FIFO non-empty → FETCH: mem_addr<=FIFO head, pop.
  - LUTW: mem_mode=1, mem_addr/mem_data = latched values for exactly one cycle; → IDLE; mem_mode returns to 0.
  - FETCH → WAIT (RAM samples address).
  - WAIT: mem_q valid.
    - If mem_q[11:8]==0: set zero_len, → IDLE, nothing issued.
    - Else code<=mem_q[7:0], length<=mem_q[11:8], code_valid<=1, → ISSUE.
  - ISSUE: hold code/length/code_valid stable until code_valid&coder_ready. On that edge: code_valid<=0, counter+1, → IDLE.
- LUT_WR handshake:
  - Write while no LUT write pending: latched, waitrequest=0.
  - Write while a previous LUT write is still pending: waitrequest=1 combinationally until the pending one enters LUTW.
- Latency: symbol write accepted at edge E0 with FSM IDLE and coder_ready=1 → FETCH after E1, WAIT after E2, code_valid high after E3. Best-case throughput is 1 codeword / 4 cycles.
- FIFO:
  - Push when full: data dropped, overflow<=1.
  - Push and pop on the same edge: count unchanged.
  - Pointers wrap mod FIFO_DEPTH.
- enable=0: the FSM finishes any in-flight FETCH/WAIT/ISSUE, then stays IDLE. LUT writes are still serviced.
- flush:
  - FIFO emptied on the next edge.
  - An in-flight lookup completes normally.
  - A push on the same edge as flush is discarded.
- Clear (CTRL bit2) and a flag-set on the same edge: set wins.
- reset mid-operation: code_valid drops on that edge, pending LUT write is lost, FIFO emptied.

Test Plan:
- Reset then read STATUS → readdata=0x00000100 (empty=1) one cycle later; all outputs 0.
- LUT_WR writedata={length=3,code=0x05,addr=7}=0x0000C147 → one cycle mem_mode=1, mem_addr=7, mem_data=12'h305. Back-to-back second LUT_WR → waitrequest=1 for one cycle.
- CTRL enable=1, SYMBOL=7 with LUT model returning 12'h305, coder_ready=1 → code_valid high exactly after E3 with code=0x05, length=3; STATUS[31:16]=1.
- coder_ready=0 for 5 cycles during ISSUE → code/length held, code_valid stays 1; single transfer when ready rises; counter increments once.
- 17 symbol pushes with enable=0 (FIFO_DEPTH=16) → count=16, full=1, overflow=1. Then CTRL bit2 → overflow=0. Then flush → count=0, empty=1.
- LUT entry length=0 for symbol 3, push 3 → no code_valid, zero_len=1, FSM back to IDLE after WAIT.
